// File: rtl/idr_operand_stage.sv
// idr_operand_stage: register-read (IDR) stage of the RV64 pipeline.
// Holds the decoded instruction, exports its source addresses to the
// forwarding unit, resolves operands from forwarded or register-file data
// and launches the bundle into the ID/EXB pipeline register.
// Optional build macro IDR_PERF_CNT_EN adds bubble/issue performance counters.
module idr_operand_stage #(
    parameter int XLEN        = 64,
    parameter int CTRL_W      = 16,
    parameter int STALL_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_ID,
    input  logic [XLEN-1:0]   pc_ID,
    input  logic [4:0]        rs1_ID,
    input  logic [4:0]        rs2_ID,
    input  logic [4:0]        rd_ID,
    input  logic              rf_wr_en_ID,
    input  logic [XLEN-1:0]   imm_ID,
    input  logic [CTRL_W-1:0] ctrl_ID,
    output logic [4:0]        rs1_IDR,
    output logic [4:0]        rs2_IDR,
    input  logic [XLEN-1:0]   rf_rs1_data,
    input  logic [XLEN-1:0]   rf_rs2_data,
    input  logic              no_forwarding_data,
    input  logic              forward_rs1_sel,
    input  logic              forward_rs2_sel,
    input  logic [XLEN-1:0]   forward_rs1_data,
    input  logic [XLEN-1:0]   forward_rs2_data,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              stall_ID,
    output logic              valid_EXB,
    output logic              rf_wr_en_EXB,
    output logic [XLEN-1:0]   pc_EXB,
    output logic [XLEN-1:0]   imm_EXB,
    output logic [XLEN-1:0]   rs1_data_EXB,
    output logic [XLEN-1:0]   rs2_data_EXB,
    output logic [4:0]        rd_EXB,
    output logic [CTRL_W-1:0] ctrl_EXB,
    output logic              stall_timeout
`ifdef IDR_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_issue_cnt
`endif
);

    localparam int CNT_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    // IDR register
    logic              valid_idr_q, valid_idr_d;
    logic [XLEN-1:0]   pc_idr_q, pc_idr_d;
    logic [4:0]        rs1_idr_q, rs1_idr_d;
    logic [4:0]        rs2_idr_q, rs2_idr_d;
    logic [4:0]        rd_idr_q, rd_idr_d;
    logic              wr_idr_q, wr_idr_d;
    logic [XLEN-1:0]   imm_idr_q, imm_idr_d;
    logic [CTRL_W-1:0] ctrl_idr_q, ctrl_idr_d;

    // ID/EXB register
    logic              valid_exb_q, valid_exb_d;
    logic              wr_exb_q, wr_exb_d;
    logic [XLEN-1:0]   pc_exb_q, pc_exb_d;
    logic [XLEN-1:0]   imm_exb_q, imm_exb_d;
    logic [XLEN-1:0]   op1_exb_q, op1_exb_d;
    logic [XLEN-1:0]   op2_exb_q, op2_exb_d;
    logic [4:0]        rd_exb_q, rd_exb_d;
    logic [CTRL_W-1:0] ctrl_exb_q, ctrl_exb_d;

    // Stall watchdog
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              timeout_q, timeout_d;

    logic              hazard;
    logic              do_hold;
    logic              do_bubble;
    logic              do_advance;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;

    // An empty stage exports x0 so it can never match a forwarding compare.
    assign rs1_IDR = valid_idr_q ? rs1_idr_q : 5'd0;
    assign rs2_IDR = valid_idr_q ? rs2_idr_q : 5'd0;

    // Action for this edge, in priority order flush > ex_hold > hazard > advance.
    assign hazard     = valid_idr_q & no_forwarding_data;
    assign do_hold    = ~flush & ex_hold;
    assign do_bubble  = ~flush & ~ex_hold & hazard;
    assign do_advance = ~flush & ~ex_hold & ~hazard;

    // Upstream hold; forced low in reset and on flush so ID can present the redirect.
    assign stall_ID = rst_n & ~flush & (ex_hold | hazard);

    // Operand resolution: x0 reads zero, otherwise forwarded data beats the register file.
    always_comb begin
        op1 = '0;
        op2 = '0;
        if (rs1_IDR != 5'd0) op1 = forward_rs1_sel ? forward_rs1_data : rf_rs1_data;
        if (rs2_IDR != 5'd0) op2 = forward_rs2_sel ? forward_rs2_data : rf_rs2_data;
    end

    // Next-state for the IDR and EXB registers plus the stall watchdog.
    always_comb begin
        valid_idr_d = valid_idr_q;
        pc_idr_d    = pc_idr_q;
        rs1_idr_d   = rs1_idr_q;
        rs2_idr_d   = rs2_idr_q;
        rd_idr_d    = rd_idr_q;
        wr_idr_d    = wr_idr_q;
        imm_idr_d   = imm_idr_q;
        ctrl_idr_d  = ctrl_idr_q;
        valid_exb_d = valid_exb_q;
        wr_exb_d    = wr_exb_q;
        pc_exb_d    = pc_exb_q;
        imm_exb_d   = imm_exb_q;
        op1_exb_d   = op1_exb_q;
        op2_exb_d   = op2_exb_q;
        rd_exb_d    = rd_exb_q;
        ctrl_exb_d  = ctrl_exb_q;
        stall_cnt_d = '0;
        timeout_d   = timeout_q;

        if (flush) begin
            valid_idr_d = 1'b0;
            valid_exb_d = 1'b0;
            wr_exb_d    = 1'b0;
        end else if (do_bubble) begin
            valid_exb_d = 1'b0;
            wr_exb_d    = 1'b0;
            pc_exb_d    = '0;
            imm_exb_d   = '0;
            op1_exb_d   = '0;
            op2_exb_d   = '0;
            rd_exb_d    = 5'd0;
            ctrl_exb_d  = '0;
            stall_cnt_d = (stall_cnt_q == LIMIT) ? stall_cnt_q : stall_cnt_q + 1'b1;
            if (stall_cnt_d == LIMIT) timeout_d = 1'b1;
        end else if (do_advance) begin
            valid_exb_d = valid_idr_q;
            wr_exb_d    = valid_idr_q & wr_idr_q;
            pc_exb_d    = pc_idr_q;
            imm_exb_d   = imm_idr_q;
            op1_exb_d   = op1;
            op2_exb_d   = op2;
            rd_exb_d    = rd_idr_q;
            ctrl_exb_d  = ctrl_idr_q;
            valid_idr_d = valid_ID;
            pc_idr_d    = pc_ID;
            rs1_idr_d   = rs1_ID;
            rs2_idr_d   = rs2_ID;
            rd_idr_d    = rd_ID;
            wr_idr_d    = rf_wr_en_ID;
            imm_idr_d   = imm_ID;
            ctrl_idr_d  = ctrl_ID;
        end
    end

    // Pipeline and watchdog registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_idr_q <= 1'b0;
            pc_idr_q    <= '0;
            rs1_idr_q   <= 5'd0;
            rs2_idr_q   <= 5'd0;
            rd_idr_q    <= 5'd0;
            wr_idr_q    <= 1'b0;
            imm_idr_q   <= '0;
            ctrl_idr_q  <= '0;
            valid_exb_q <= 1'b0;
            wr_exb_q    <= 1'b0;
            pc_exb_q    <= '0;
            imm_exb_q   <= '0;
            op1_exb_q   <= '0;
            op2_exb_q   <= '0;
            rd_exb_q    <= 5'd0;
            ctrl_exb_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            valid_idr_q <= valid_idr_d;
            pc_idr_q    <= pc_idr_d;
            rs1_idr_q   <= rs1_idr_d;
            rs2_idr_q   <= rs2_idr_d;
            rd_idr_q    <= rd_idr_d;
            wr_idr_q    <= wr_idr_d;
            imm_idr_q   <= imm_idr_d;
            ctrl_idr_q  <= ctrl_idr_d;
            valid_exb_q <= valid_exb_d;
            wr_exb_q    <= wr_exb_d;
            pc_exb_q    <= pc_exb_d;
            imm_exb_q   <= imm_exb_d;
            op1_exb_q   <= op1_exb_d;
            op2_exb_q   <= op2_exb_d;
            rd_exb_q    <= rd_exb_d;
            ctrl_exb_q  <= ctrl_exb_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign valid_EXB     = valid_exb_q;
    assign rf_wr_en_EXB  = wr_exb_q;
    assign pc_EXB        = pc_exb_q;
    assign imm_EXB       = imm_exb_q;
    assign rs1_data_EXB  = op1_exb_q;
    assign rs2_data_EXB  = op2_exb_q;
    assign rd_EXB        = rd_exb_q;
    assign ctrl_EXB      = ctrl_exb_q;
    assign stall_timeout = timeout_q;

`ifdef IDR_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] issue_cnt_q;

    // Free-running wrap-around counters of inserted bubbles and launched instructions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= 32'd0;
            issue_cnt_q  <= 32'd0;
        end else begin
            if (do_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (do_advance && valid_idr_q) issue_cnt_q <= issue_cnt_q + 32'd1;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_issue_cnt  = issue_cnt_q;
`endif

endmodule
